// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// FSM state encoding and requester identifiers.
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and
// moves only when both requesters compete in the same cycle.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  req_id_e ptr_q;
  req_id_e ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // An uncontested request is granted without consulting the pointer.
  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_mem_o = 1'b0;
    ptr_d     = ptr_q;
    if (en_i) begin
      if (req_alu_i && req_mem_i) begin
        if (ptr_q == REQ_ALU) begin
          gnt_alu_o = 1'b1;
          ptr_d     = REQ_MEM;
        end else begin
          gnt_mem_o = 1'b1;
          ptr_d     = REQ_ALU;
        end
      end else begin
        gnt_alu_o = req_alu_i;
        gnt_mem_o = req_mem_i;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port shared by the ALU and load unit: clears every
// register after reset, then arbitrates writebacks into a registered write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic              init_done,
  output logic [15:0]       conflict_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       conflict_q, conflict_d;

  logic              run;
  logic              alu_gnt;
  logic              mem_gnt;
  logic              xfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  assign run = (state_q == ST_RUN);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (run),
    .req_alu_i (alu_valid),
    .req_mem_i (mem_valid),
    .gnt_alu_o (alu_gnt),
    .gnt_mem_o (mem_gnt)
  );

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // At most one grant is ever high, so a simple select picks the winner.
  always_comb begin
    xfer     = 1'b0;
    win_rd   = '0;
    win_data = '0;
    if (alu_valid && alu_gnt) begin
      xfer     = 1'b1;
      win_rd   = alu_rd;
      win_data = alu_data;
    end else if (mem_valid && mem_gnt) begin
      xfer     = 1'b1;
      win_rd   = mem_rd;
      win_data = mem_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_CLEAR: begin
        regwrite_d = 1'b1;
        wreg_d     = idx_q;
        wdata_d    = '0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Writes to x0 still complete the handshake but never reach the file.
        if (xfer && (win_rd != '0)) begin
          regwrite_d = 1'b1;
          wreg_d     = win_rd;
          wdata_d    = win_data;
        end
        if (alu_valid && mem_valid && (conflict_q != CNT_MAX)) begin
          conflict_d = conflict_q + 16'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      conflict_q <= conflict_d;
    end
  end

  assign RegWrite       = regwrite_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign init_done      = run;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised scoreboard bench for regfile_write_arbiter: expected writes are
// queued with their due cycle and a monitor matches them against the write port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [63:0] Write_data;
  logic        init_done;
  logic [15:0] conflict_count;

  regfile_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .init_done      (init_done),
    .conflict_count (conflict_count)
  );

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prefAlu = 1'b1;
  int   modelConf = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each registered write must match the oldest expectation due now.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
        exp_t e;
        e = expQ.pop_front();
        checkVal("write_enable", {63'd0, RegWrite}, 64'd1);
        checkVal("write_register", {59'd0, Write_register}, {59'd0, e.rd});
        checkVal("write_data", Write_data, e.data);
      end else if (RegWrite === 1'b1) begin
        checkVal("unexpected_write", {63'd0, RegWrite}, 64'd0);
      end
    end
  end

  task automatic stepTo();
    @(negedge clk);
    #2;
  endtask

  task automatic checkReset();
    checkVal("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
    checkVal("rst_Write_register", {59'd0, Write_register}, 64'd0);
    checkVal("rst_Write_data", Write_data, 64'd0);
    checkVal("rst_init_done", {63'd0, init_done}, 64'd0);
    checkVal("rst_conflict_count", {48'd0, conflict_count}, 64'd0);
    checkVal("rst_readies", {62'd0, alu_ready, mem_ready}, 64'd0);
  endtask

  task automatic applyReset();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkReset();
    expQ.delete();
    prefAlu = 1'b1;
    modelConf = 0;
  endtask

  // Releases reset and expects one zero write per register; stop < 32 abandons early.
  task automatic runClear(input int stop);
    int c0;
    rst = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      e.due = c0 + 1 + i;
      e.rd = 5'(i);
      e.data = 64'd0;
      expQ.push_back(e);
    end
    for (int k = 1; k <= stop; k++) begin
      stepTo();
      if (k == 31) checkVal("init_done_during_clear", {63'd0, init_done}, 64'd0);
      if (k == 32) checkVal("init_done_after_clear", {63'd0, init_done}, 64'd1);
      if (k < 32) checkVal("ready_during_clear", {62'd0, alu_ready, mem_ready}, 64'd0);
    end
  endtask

  // Drives one RUN cycle and applies the reference arbitration rules.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                               output logic ga, output logic gm);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    if (av && mv) begin
      ga = prefAlu;
      gm = !prefAlu;
      prefAlu = !prefAlu;
    end else begin
      ga = av;
      gm = mv;
    end
    #1;
    checkVal("alu_ready", {63'd0, alu_ready}, {63'd0, ga});
    checkVal("mem_ready", {63'd0, mem_ready}, {63'd0, gm});
    checkVal("conflict_count", {48'd0, conflict_count}, 64'(modelConf));
    if (av && mv && modelConf < 65535) modelConf++;
    if ((ga && ard != 5'd0) || (gm && mrd != 5'd0)) begin
      exp_t e;
      e.due = cyc + 1;
      e.rd = ga ? ard : mrd;
      e.data = ga ? ad : md;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    checkVal("queue_drained", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic ga, gm;
    logic aV, mV, aHold, mHold;
    logic [4:0] aRd, mRd;
    logic [63:0] aD, mD;

    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (3) stepTo();
    applyReset();
    stepTo();
    runClear(32);

    applyStimulus(1'b1, 5'd5, 64'h5, 1'b0, 5'd0, 64'd0, ga, gm);
    stepTo();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, ga, gm);
      stepTo();
    end
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, ga, gm);
    stepTo();
    applyStimulus(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 64'hB, ga, gm);
    stepTo();
    applyStimulus(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 64'hB, ga, gm);
    stepTo();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, ga, gm);
    stepTo();

    aHold = 1'b0; mHold = 1'b0;
    aV = 1'b0; mV = 1'b0; aRd = '0; mRd = '0; aD = '0; mD = '0;
    for (int i = 0; i < 400; i++) begin
      if (!aHold) begin
        aV  = ($urandom_range(0, 99) < 65);
        aRd = 5'($urandom_range(0, 31));
        aD  = {$urandom, $urandom};
      end
      if (!mHold) begin
        mV  = ($urandom_range(0, 99) < 65);
        mRd = 5'($urandom_range(0, 31));
        mD  = {$urandom, $urandom};
      end
      applyStimulus(aV, aRd, aD, mV, mRd, mD, ga, gm);
      aHold = aV && !ga;
      mHold = mV && !gm;
      stepTo();
    end
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, ga, gm);
    stepTo();
    checkOutput();

    applyReset();
    stepTo();
    runClear(10);
    applyReset();
    stepTo();
    stepTo();
    runClear(32);
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, ga, gm);
    stepTo();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, ga, gm);
    stepTo();
    stepTo();
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width.
REQ-003 SHALL have parameter NUM_REGS, default 32, registers cleared at init.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 alu_valid  input  1  ALU writeback request.
REQ-007 alu_rd  input  ADDR_W  ALU destination register.
REQ-008 alu_data  input  DATA_W  ALU result.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 mem_valid  input  1  load-unit writeback request.
REQ-011 mem_rd  input  ADDR_W  load destination register.
REQ-012 mem_data  input  DATA_W  load data.
REQ-013 mem_ready  output  1  load request accepted this cycle.
REQ-014 RegWrite  output  1  register-file write enable, registered.
REQ-015 Write_register  output  ADDR_W  register-file write index, registered.
REQ-016 Write_data  output  DATA_W  register-file write data, registered.
REQ-017 init_done  output  1  high once the clear sequence has finished.
REQ-018 conflict_count  output  16  saturating count of cycles with both requests valid in RUN.

Function
REQ-019 FSM SHALL have two states: CLEAR (initial) and RUN; RUN is terminal until reset.
REQ-020 In CLEAR, per cycle: issue RegWrite=1, Write_register=idx, Write_data=0; then idx+1, starting at idx=0.
REQ-021 After issuing idx=NUM_REGS-1, SHALL move to RUN; exactly NUM_REGS consecutive clear writes.
REQ-022 In CLEAR, alu_ready=mem_ready=0 and init_done=0; in RUN, init_done=1.
REQ-023 Readies SHALL be combinational from state, valids and priority pointer; at most one ready high per cycle.
REQ-024 A transfer occurs when valid&ready; requester SHALL hold rd/data stable while valid&!ready.
REQ-025 Single valid requester in RUN SHALL get ready the same cycle.
REQ-026 Both valid: grant the requester indicated by the priority pointer; after the grant, pointer moves to the other requester.
REQ-027 Pointer SHALL update only on a contended grant; reset value = ALU preferred.
REQ-028 Latency: transfer in cycle N -> RegWrite=1 with that rd/data in cycle N+1 (1-cycle registered output).
REQ-029 No transfer in cycle N -> RegWrite=0 in N+1; Write_register/Write_data hold their last values.
REQ-030 Transfer with rd=0 SHALL complete the handshake but produce RegWrite=0 (x0 write suppressed).
REQ-031 Both requesters targeting the same rd SHALL be serialized; the later-granted value persists.
REQ-032 conflict_count +1 each RUN cycle with alu_valid&mem_valid, saturating at 16'hFFFF.
REQ-033 Throughput: one write per cycle sustained; no bubble between back-to-back grants.

Reset
REQ-034 rst asserted SHALL immediately force: state=CLEAR, idx=0, pointer=ALU, RegWrite=0, Write_register=0, Write_data=0, init_done=0, conflict_count=0, readies=0.
REQ-035 Reset mid-CLEAR or mid-RUN SHALL abandon pending work; the full clear sequence restarts from idx 0 on the first edge after release.

Structure
REQ-036 Shared package regfile_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS defaults, the state enum {ST_CLEAR, ST_RUN} and requester IDs {REQ_ALU, REQ_MEM}.
REQ-037 Two-way round-robin grant logic with pointer SHALL be a sub-module rr_arbiter2; FSM, clear counter, output register and counter stay in the top.

Verification
REQ-038 Release reset, no requests -> RegWrite=1 for 32 cycles, Write_register 0..31, Write_data 0; init_done=1 after; then RegWrite=0.
REQ-039 RUN, alu_valid only, rd=5, data=64'h5 -> alu_ready=1 same cycle; next cycle RegWrite=1, Write_register=5, Write_data=5.
REQ-040 RUN, both valid for 4 cycles (ALU rd=1, MEM rd=2) -> grants ALU, MEM, ALU, MEM; conflict_count=4.
REQ-041 RUN, mem_valid rd=0, data=64'hFF -> mem_ready=1; next cycle RegWrite=0.
REQ-042 Assert rst at clear idx=10, release -> clear restarts at Write_register=0, 32 writes total; conflict_count=0, pointer=ALU.
